// File: rtl/seq_detect_param_if.sv
// Serial stream bundle for seq_detect_param: data/control toward the detector,
// match flag and match count back from it.
interface seq_detect_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             d;
  logic             d_valid;
  logic             overlap;
  logic             load;
  logic [PAT_W-1:0] pattern;
  logic             y;
  logic [CNT_W-1:0] match_count;

  modport master (
    output d, d_valid, overlap, load, pattern,
    input  y, match_count
  );

  modport slave (
    input  d, d_valid, overlap, load, pattern,
    output y, match_count
  );
endinterface

// File: rtl/seq_detect_param.sv
// Programmable MSB-first serial pattern detector with a registered one-cycle match pulse.
// Optional saturating match counter is built when SEQDET_COUNT_EN is defined.
module seq_detect_param #(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] RESET_PAT = 4'b1101,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  seq_detect_param_if.slave bus
);
  localparam int                FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_reg, pat_nxt;
  logic [PAT_W-1:0]  hist, hist_nxt, nh;
  logic [FILL_W-1:0] fill, fill_nxt, nf;
  logic              match_p0;
  logic              y_p1;

  // Stage 0: shift-compare decision for the bit consumed on this edge
  always_comb begin
    nh       = {hist[PAT_W-2:0], bus.d};
    nf       = (fill == FULL) ? FULL : fill + 1'b1;
    match_p0 = 1'b0;
    pat_nxt  = pat_reg;
    hist_nxt = hist;
    fill_nxt = fill;
    if (bus.load) begin
      pat_nxt  = bus.pattern;
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (bus.d_valid) begin
      hist_nxt = nh;
      if ((nf == FULL) && (nh == pat_reg)) begin
        match_p0 = 1'b1;
        // Non-overlapping mode discards the matched bits entirely
        fill_nxt = bus.overlap ? FULL : '0;
      end else begin
        fill_nxt = nf;
      end
    end
  end

  // Stage 1: registered state and Moore match flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_reg <= RESET_PAT;
      hist    <= '0;
      fill    <= '0;
      y_p1    <= 1'b0;
    end else begin
      pat_reg <= pat_nxt;
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      y_p1    <= match_p0 & ~bus.load;
    end
  end

  assign bus.y = y_p1;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p1 <= '0;
    end else if (bus.load) begin
      cnt_p1 <= '0;
    end else if (match_p0) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign bus.match_count = cnt_p1;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised and directed bench for seq_detect_param against a bit-queue reference model.
// Two instances share one stimulus stream: an 8-bit counter and a 2-bit (saturating) counter.
module tb_seq_detect_param;
  localparam int PAT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(8)) bus ();
  seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(2)) bus2 ();

  assign bus2.d       = bus.d;
  assign bus2.d_valid = bus.d_valid;
  assign bus2.overlap = bus.overlap;
  assign bus2.load    = bus.load;
  assign bus2.pattern = bus.pattern;

  seq_detect_param #(.PAT_W(PAT_W), .RESET_PAT(4'b1101), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  seq_detect_param #(.PAT_W(PAT_W), .RESET_PAT(4'b1101), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  // Reference model: the consumed bits since the last reset/load/non-overlap match
  logic       q[$];
  logic [3:0] mpat;
  int         mcnt;
  logic       ey;

  function automatic bit model_hit();
    if (q.size() != PAT_W) return 1'b0;
    for (int i = 0; i < PAT_W; i++)
      if (q[i] != mpat[PAT_W-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_cnt(input int w);
`ifdef SEQDET_COUNT_EN
    int top;
    top = (1 << w) - 1;
    return (mcnt > top) ? top : mcnt;
`else
    return (w > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    mpat = 4'b1101;
    mcnt = 0;
    ey   = 1'b0;
  endtask

  // Drive one clock of stimulus and advance the model; leaves inputs idle afterwards
  task automatic apply(input logic d, input logic v, input logic ov, input logic ld,
                       input logic [3:0] p);
    @(negedge clk);
    bus.d = d; bus.d_valid = v; bus.overlap = ov; bus.load = ld; bus.pattern = p;
    @(posedge clk);
    #1;
    if (ld) begin
      mpat = p; q.delete(); mcnt = 0; ey = 1'b0;
    end else if (v) begin
      q.push_back(d);
      if (q.size() > PAT_W) void'(q.pop_front());
      ey = model_hit();
      if (ey) begin
        mcnt++;
        if (!ov) q.delete();
      end
    end else begin
      ey = 1'b0;
    end
    bus.d_valid = 1'b0;
    bus.load    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.d = 1'b1; bus.d_valid = 1'b1; bus.overlap = 1'b1; bus.load = 1'b0; bus.pattern = 4'b1101;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL reset_y got %b want 0", bus.y); end
    n_vec++; if (bus.match_count !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", bus.match_count); end
    n_vec++; if (bus2.match_count !== 2'd0) begin n_err++; $display("FAIL reset_cnt2 got %0d want 0", bus2.match_count); end
    bus.d_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_stream(input string name, input logic ov, input int want_pulses);
    logic [6:0] bits;
    int pulses;
    bits = 7'b1101101;
    pulses = 0;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      apply(bits[i], 1'b1, ov, 1'b0, 4'h0);
      if (bus.y === 1'b1) pulses++;
      n_vec++; if (bus.y !== ey) begin n_err++; $display("FAIL %s_y bit%0d got %b want %b", name, 6-i, bus.y, ey); end
      n_vec++; if (bus.match_count !== exp_cnt(8)) begin n_err++; $display("FAIL %s_cnt bit%0d got %0d want %0d", name, 6-i, bus.match_count, exp_cnt(8)); end
    end
    n_vec++; if (pulses != want_pulses) begin n_err++; $display("FAIL %s_pulses got %0d want %0d", name, pulses, want_pulses); end
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    int pulses;
    bits = 4'b1101;
    pulses = 0;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      apply(bits[i], 1'b1, 1'b1, 1'b0, 4'h0);
      if (bus.y === 1'b1) pulses++;
      n_vec++; if (bus.y !== ey) begin n_err++; $display("FAIL gaps_y bit%0d got %b want %b", 3-i, bus.y, ey); end
      for (int g = 0; g < 3; g++) begin
        apply(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 4'h0);
        n_vec++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL gaps_idle_y got %b want 0", bus.y); end
      end
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL gaps_pulses got %0d want 1", pulses); end
    n_vec++; if (bus.match_count !== exp_cnt(8)) begin n_err++; $display("FAIL gaps_cnt got %0d want %0d", bus.match_count, exp_cnt(8)); end
  endtask

  task automatic test_load();
    logic [6:0] bits;
    int pulses;
    bits = 7'b0110110;
    pulses = 0;
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
    n_vec++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL load_y got %b want 0", bus.y); end
    n_vec++; if (bus.match_count !== 8'd0) begin n_err++; $display("FAIL load_clr_cnt got %0d want 0", bus.match_count); end
    for (int i = 6; i >= 0; i--) begin
      apply(bits[i], 1'b1, 1'b1, 1'b0, 4'h0);
      if (bus.y === 1'b1) pulses++;
      n_vec++; if (bus.y !== ey) begin n_err++; $display("FAIL load_y bit%0d got %b want %b", 6-i, bus.y, ey); end
    end
    n_vec++; if (pulses != 2) begin n_err++; $display("FAIL load_pulses got %0d want 2", pulses); end
    n_vec++; if (bus.match_count !== exp_cnt(8)) begin n_err++; $display("FAIL load_cnt got %0d want %0d", bus.match_count, exp_cnt(8)); end
  endtask

  task automatic test_saturate();
    logic [15:0] bits;
    int pulses;
    bits = 16'b1101101101101101;
    pulses = 0;
    apply(1'b0, 1'b0, 1'b1, 1'b1, 4'b1101);
    for (int i = 15; i >= 0; i--) begin
      apply(bits[i], 1'b1, 1'b1, 1'b0, 4'h0);
      if (bus2.y === 1'b1) pulses++;
      n_vec++; if (bus2.y !== ey) begin n_err++; $display("FAIL sat_y bit%0d got %b want %b", 15-i, bus2.y, ey); end
      n_vec++; if (bus2.match_count !== exp_cnt(2)) begin n_err++; $display("FAIL sat_cnt2 bit%0d got %0d want %0d", 15-i, bus2.match_count, exp_cnt(2)); end
    end
    n_vec++; if (pulses != 5) begin n_err++; $display("FAIL sat_pulses got %0d want 5", pulses); end
`ifdef SEQDET_COUNT_EN
    n_vec++; if (bus2.match_count !== 2'd3) begin n_err++; $display("FAIL sat_stick got %0d want 3", bus2.match_count); end
    n_vec++; if (bus.match_count !== 8'd5) begin n_err++; $display("FAIL sat_cnt8 got %0d want 5", bus.match_count); end
`else
    n_vec++; if (bus2.match_count !== 2'd0) begin n_err++; $display("FAIL sat_off got %0d want 0", bus2.match_count); end
`endif
  endtask

  task automatic test_reset_midstream();
    logic [3:0] bits;
    bits = 4'b1101;
    for (int i = 3; i >= 0; i--) apply(bits[i], 1'b1, 1'b1, 1'b0, 4'h0);
    n_vec++; if (bus.y !== 1'b1) begin n_err++; $display("FAIL mid_pre_y got %b want 1", bus.y); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_vec++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL mid_async_y got %b want 0", bus.y); end
    n_vec++; if (bus.match_count !== 8'd0) begin n_err++; $display("FAIL mid_async_cnt got %0d want 0", bus.match_count); end
    n_vec++; if (bus2.match_count !== 2'd0) begin n_err++; $display("FAIL mid_async_cnt2 got %0d want 0", bus2.match_count); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      apply(bits[i], 1'b1, 1'b1, 1'b0, 4'h0);
      n_vec++; if (bus.y !== ey) begin n_err++; $display("FAIL mid_y bit%0d got %b want %b", 3-i, bus.y, ey); end
    end
    do_reset();
    apply(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    n_vec++; if (bus.y !== 1'b0) begin n_err++; $display("FAIL mid_lost_y got %b want 0", bus.y); end
    n_vec++; if (bus.y !== ey) begin n_err++; $display("FAIL mid_model_y got %b want %b", bus.y, ey); end
  endtask

  task automatic test_random();
    logic d, v, ov, ld;
    logic [3:0] p;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      d  = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      ov = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 59) == 0);
      p  = 4'($urandom);
      apply(d, v, ov, ld, p);
      n_vec++; if (bus.y !== ey) begin n_err++; $display("FAIL rand_y cyc%0d got %b want %b", n, bus.y, ey); end
      n_vec++; if (bus.match_count !== exp_cnt(8)) begin n_err++; $display("FAIL rand_cnt cyc%0d got %0d want %0d", n, bus.match_count, exp_cnt(8)); end
      n_vec++; if (bus2.match_count !== exp_cnt(2)) begin n_err++; $display("FAIL rand_cnt2 cyc%0d got %0d want %0d", n, bus2.match_count, exp_cnt(2)); end
    end
  endtask

  initial begin
    test_reset();
    test_stream("overlap", 1'b1, 2);
    test_stream("nonoverlap", 1'b0, 1);
    test_gaps();
    test_load();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
